// File: rtl/serial_mag_comp_if.sv
// Start/operand/result bundle for the serial magnitude comparator.
// master drives the request side, slave is the comparator.
interface serial_mag_comp_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_eq_b;
    logic             a_lt_b;
    logic             a_gt_b;

    modport master (
        output start, a, b,
        input  busy, done, a_eq_b, a_lt_b, a_gt_b
    );

    modport slave (
        input  start, a, b,
        output busy, done, a_eq_b, a_lt_b, a_gt_b
    );
endinterface

// File: rtl/serial_mag_comp.sv
// MSB-first serial magnitude comparator around one compfull1b.
// Define SERIAL_COMP_EARLY_EXIT_EN to finish on the first differing bit.
module compfull1b (
    input  logic a,
    input  logic b,
    output logic a_eq_b,
    output logic a_lt_b,
    output logic a_gt_b
);
    assign a_eq_b = (a == b);
    assign a_lt_b = ~a & b;
    assign a_gt_b = a & ~b;
endmodule

module serial_mag_comp #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_mag_comp_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             decided_q, decided_d;
    logic             pol_gt_q, pol_gt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;

    logic c_eq, c_lt, c_gt;
    logic first_diff;
    logic leave;

    compfull1b u_bit (
        .a      (sa_q[WIDTH-1]),
        .b      (sb_q[WIDTH-1]),
        .a_eq_b (c_eq),
        .a_lt_b (c_lt),
        .a_gt_b (c_gt)
    );

    assign first_diff = ~decided_q & (c_lt | c_gt);

`ifdef SERIAL_COMP_EARLY_EXIT_EN
    assign leave = (cnt_q == '0) | first_diff;
`else
    assign leave = (cnt_q == '0);
`endif

    always_comb begin
        state_d   = state_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        pol_gt_d  = pol_gt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        eq_d      = eq_q;
        lt_d      = lt_q;
        gt_d      = gt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sa_d      = bus.a;
                    sb_d      = bus.b;
                    cnt_d     = CW'(WIDTH - 1);
                    decided_d = 1'b0;
                    pol_gt_d  = 1'b0;
                    eq_d      = 1'b0;
                    lt_d      = 1'b0;
                    gt_d      = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                sa_d  = sa_q << 1;
                sb_d  = sb_q << 1;
                cnt_d = cnt_q - 1'b1;
                if (first_diff) begin
                    decided_d = 1'b1;
                    pol_gt_d  = c_gt;
                end
                if (leave) begin
                    // a latched polarity always wins over the current bit
                    gt_d    = decided_q ? pol_gt_q : c_gt;
                    lt_d    = decided_q ? ~pol_gt_q : c_lt;
                    eq_d    = ~decided_q & c_eq;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sa_q      <= '0;
            sb_q      <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            pol_gt_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            gt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            pol_gt_q  <= pol_gt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
            gt_q      <= gt_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.a_eq_b = eq_q;
    assign bus.a_lt_b = lt_q;
    assign bus.a_gt_b = gt_q;
endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed bench for serial_mag_comp, WIDTH=8.
// Expected latency follows SERIAL_COMP_EARLY_EXIT_EN when defined.
module tb_serial_mag_comp;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_chk;

    serial_mag_comp_if #(.WIDTH(W)) bus ();

    serial_mag_comp #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] R_EQ = 3'b100;
    localparam logic [2:0] R_LT = 3'b010;
    localparam logic [2:0] R_GT = 3'b001;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [4:0] flags();
        return {bus.busy, bus.done, bus.a_eq_b, bus.a_lt_b, bus.a_gt_b};
    endfunction

    function automatic int exp_lat(input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        int lat;
        lat = W + 1;
`ifdef SERIAL_COMP_EARLY_EXIT_EN
        for (int i = W - 1; i >= 0; i--) begin
            if (a[i] != b[i]) begin
                lat = W - i + 1;
                break;
            end
        end
`endif
        return lat;
    endfunction

    task automatic wait_done(input string tag, output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                n = i;
                break;
            end
            check({tag, "_busy"}, {59'd0, flags()}, 64'b10000);
        end
        if (n == 0) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    // Called at a negedge; returns at the negedge of the IDLE cycle.
    task automatic run(input string tag, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2:0] res);
        int n;
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = ~a;
        bus.b = a;
        wait_done(tag, n);
        check({tag, "_lat"}, 64'(n), 64'(exp_lat(a, b)));
        check({tag, "_res"}, {59'd0, flags()}, {59'd0, 2'b01, res});
        @(negedge clk);
        check({tag, "_hold"}, {59'd0, flags()}, {59'd0, 2'b00, res});
    endtask

    initial begin
        int n;
        logic seen;
        n_pass = 0;
        n_chk = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {59'd0, flags()}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_state", {59'd0, flags()}, 64'd0);

        run("eq_a5", 8'hA5, 8'hA5, R_EQ);
        run("gt_80", 8'h80, 8'h7F, R_GT);
        run("lt_lsb", 8'h00, 8'h01, R_LT);

        bus.start = 1'b1;
        bus.a = 8'h10;
        bus.b = 8'h20;
        @(posedge clk);
        #1;
        bus.a = 8'h55;
        bus.b = 8'h55;
        wait_done("held1", n);
        check("held1_lat", 64'(n), 64'(exp_lat(8'h10, 8'h20)));
        check("held1_res", {59'd0, flags()}, 64'b01010);
        @(negedge clk);
        check("held_idle", {59'd0, flags()}, 64'b00010);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("held2", n);
        check("held2_lat", 64'(n), 64'(W + 1));
        check("held2_res", {59'd0, flags()}, 64'b01100);
        @(negedge clk);

        bus.start = 1'b1;
        bus.a = 8'h12;
        bus.b = 8'h34;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", {59'd0, flags()}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("rst_no_done", {63'd0, seen}, 64'd0);
        check("rst_quiet", {59'd0, flags()}, 64'd0);

        run("lt_3c", 8'h3C, 8'hC3, R_LT);
        run("gt_ff", 8'hFF, 8'hFE, R_GT);
        check("gt_ff_idle", {59'd0, flags()}, 64'b00001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/serial_mag_comp.md
Name: serial_mag_comp

Overview:
- Multi-cycle N-bit magnitude comparator built around one instance of the team's 1-bit full comparator (compfull1b).
- Captures two WIDTH-bit operands on a start handshake and shifts them MSB-first, one bit pair per clock, through compfull1b.
- Consumes compfull1b's a_eq_b/a_lt_b/a_gt_b each cycle and accumulates a registered word-level result.
- Sits directly upstream of compfull1b (feeds its a/b) and downstream of it (consumes its flags); a compact alternative to a wide parallel comparator.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..64. The bit counter width is derived internally as $clog2(WIDTH).

Ports:
- clk, input, 1, single clock, rising-edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request; accepted only in IDLE.
- a, input, WIDTH, operand A; sampled only on the accepting edge.
- b, input, WIDTH, operand B; sampled only on the accepting edge.
- busy, output, 1, high while in SHIFT.
- done, output, 1, one-cycle pulse when the result becomes valid.
- a_eq_b, output, 1, registered result A==B.
- a_lt_b, output, 1, registered result A<B (unsigned).
- a_gt_b, output, 1, registered result A>B (unsigned).

Behaviour:
- Reset:
  - Asserting rst_n low takes effect immediately, with no clock edge.
  - FSM goes to IDLE; busy, done, a_eq_b, a_lt_b and a_gt_b all become 0.
  - Shift registers, bit counter and the decided flag are cleared.
- FSM states: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE:
  - On an edge with start=1: load sa<=a, sb<=b, cnt<=WIDTH-1, decided<=0; clear all three result outputs to 0; go to SHIFT.
  - Otherwise hold, and keep the previous result stable.
- SHIFT (busy=1):
  - compfull1b inputs are sa[WIDTH-1] and sb[WIDTH-1].
  - Each edge: shift sa and sb left by 1 and decrement cnt.
  - If decided=0 and the 1-bit comparator reports lt or gt, latch that polarity and set decided=1.
  - Leave SHIFT when cnt==0 on that edge, or earlier per the Optional Feature.
- Leaving SHIFT:
  - Exactly one result is set: gt if the latched polarity is gt, lt if it is lt, otherwise eq.
  - FSM moves to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then the FSM returns to IDLE.
  - The result holds until the next accepted start.
- Latency:
  - Let start be accepted on edge k.
  - SHIFT occupies cycles k+1..k+WIDTH; done is high in cycle k+WIDTH+1.
  - With early exit, a first differing bit i (MSB = WIDTH-1) gives done in cycle k+WIDTH-i+1.
- start is ignored in SHIFT and DONE. Earliest re-accept is the first IDLE cycle, giving a throughput of WIDTH+2 cycles per compare without early exit.
- a and b may change freely after acceptance and have no effect on an operation in progress.
- Invariant: after the first done, exactly one of a_eq_b/a_lt_b/a_gt_b is 1 at all times except while busy=1. Between acceptance and done all three are 0.
- Reset mid-SHIFT: operation is abandoned and no done pulse follows reset release.
- Comparison is unsigned, MSB-first. The first differing bit alone decides the result; later bits never override it.

Optional Feature:
- Macro: SERIAL_COMP_EARLY_EXIT_EN.
- Defined: on the SHIFT edge where the first difference is detected, go directly to DONE. Latency becomes data-dependent (minimum 2 cycles from acceptance to done).
- Undefined: SHIFT always runs all WIDTH cycles (decided is sticky). Latency is fixed at WIDTH+1 cycles, giving constant-time compare.
- Functional result is identical in both builds.

Test Plan (WIDTH=8):
- a=8'hA5, b=8'hA5, start pulse:
  - busy high for 8 cycles, then done pulse 9 cycles after the accepting edge, with a_eq_b=1 and lt=gt=0 in both builds.
- a=8'h80, b=8'h7F:
  - a_gt_b=1.
  - Done 9 cycles after acceptance without the macro; 2 cycles after with SERIAL_COMP_EARLY_EXIT_EN.
- a=8'h00, b=8'h01:
  - a_lt_b=1, done 9 cycles after acceptance in both builds (difference is at the LSB).
- start held high continuously, with a/b changed while busy:
  - First operands are used.
  - The second accept occurs in the IDLE cycle after done, using the a/b present on that edge.
  - Results are all 0 between that accept and the next done.
- rst_n driven low mid-SHIFT (4 cycles in), asynchronously between edges:
  - busy, done and results go to 0 immediately.
  - After release, no done pulse until a new start.
- a=8'h3C, b=8'hC3, then a new start in the IDLE cycle after done with a=8'hFF, b=8'hFE:
  - First done gives lt=1.
  - Result stays lt=1 while IDLE, clears to 0 on re-accept, and the second done gives gt=1.
